// File: rtl/gpr_wb_scoreboard.sv
// GPR write-back scoreboard: tracks outstanding writes per GPR and stalls ID on
// read-after-write hazards or when a destination counter has no headroom left.
module gpr_wb_scoreboard #(
  parameter int ADR_W   = 5,
  parameter int NUM_GPR = 2 ** ADR_W,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_wr_en,
  input  logic [ADR_W-1:0] id_addr_reg,
  input  logic             id_use_rs,
  input  logic [ADR_W-1:0] id_addr_rs,
  input  logic             id_use_rt,
  input  logic [ADR_W-1:0] id_addr_rt,
  input  logic             wb_valid,
  input  logic [ADR_W-1:0] wb_addr,
  input  logic             flush,
  output logic             id_stall,
  output logic             id_accept,
  output logic             busy_any,
  output logic             wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NUM_GPR];
  logic [CNT_W-1:0] cnt_d [NUM_GPR];
  logic [NUM_GPR-1:0] busy;
  logic               busy_any_q, busy_any_d;
  logic               wb_err_q, wb_err_d;
  logic               src_hazard, dst_full;
  logic               issue_en, retire_req, retire_ok;

  always_comb begin
    for (int r = 0; r < NUM_GPR; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  // Stall looks only at registered counts, so a WB release is seen one cycle later.
  always_comb begin
    src_hazard = (id_use_rs & busy[id_addr_rs]) | (id_use_rt & busy[id_addr_rt]);
    dst_full   = id_wr_en & (id_addr_reg != '0) & (cnt_q[id_addr_reg] == CNT_MAX);
    id_stall   = id_valid & (src_hazard | dst_full);
    id_accept  = id_valid & ~id_stall;
  end

  always_comb begin
    issue_en   = id_accept & id_wr_en & (id_addr_reg != '0);
    retire_req = wb_valid & (wb_addr != '0);
    retire_ok  = retire_req & busy[wb_addr];
  end

  // Issue and retire compose per GPR, so the same GPR on both nets to zero change.
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NUM_GPR; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else begin
        if (issue_en && (id_addr_reg == ADR_W'(r))) begin
          cnt_d[r] = cnt_d[r] + CNT_W'(1);
        end
        if (retire_ok && (wb_addr == ADR_W'(r))) begin
          cnt_d[r] = cnt_d[r] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    wb_err_d   = wb_err_q | (~flush & retire_req & ~busy[wb_addr]);
    busy_any_d = 1'b0;
    for (int r = 1; r < NUM_GPR; r++) begin
      busy_any_d = busy_any_d | (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_GPR; r++) begin
        cnt_q[r] <= '0;
      end
      busy_any_q <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_GPR; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_any_q <= busy_any_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign busy_any = busy_any_q;
  assign wb_err   = wb_err_q;

endmodule
